// File: rtl/ps2_recv.sv
// ps2_recv: PS/2 host receiver with line glitch filtering, 11-bit frame deframing
// and E0/F0 prefix decoding into key events.
module ps2_recv #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 3750
) (
  input  logic       clk_25mhz,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release,
  output logic       key_valid
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [1:0] csync_q, csync_d, dsync_q, dsync_d;
  logic [FW-1:0] ccnt_q, ccnt_d, dcnt_q, dcnt_d;
  logic cflt_q, cflt_d, dflt_q, dflt_d, cprev_q, cprev_d, fall_q, fall_d, bit_q, bit_d;
  logic [TW-1:0] to_q, to_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] sh_q, sh_d, data_q, data_d, code_q, code_d;
  logic par_q, par_d, dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
  logic ext_q, ext_d, rel_q, rel_d, kext_q, kext_d, krel_q, krel_d, kv_q, kv_d;
  logic timeout;
  // a line flips only after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    csync_d = {csync_q[0], ps2_clk};
    dsync_d = {dsync_q[0], ps2_data};
    ccnt_d  = (csync_q[1] != cflt_q && ccnt_q != FW'(FILTER_LEN - 1)) ? ccnt_q + FW'(1) : '0;
    cflt_d  = (csync_q[1] != cflt_q && ccnt_q == FW'(FILTER_LEN - 1)) ? csync_q[1] : cflt_q;
    dcnt_d  = (dsync_q[1] != dflt_q && dcnt_q != FW'(FILTER_LEN - 1)) ? dcnt_q + FW'(1) : '0;
    dflt_d  = (dsync_q[1] != dflt_q && dcnt_q == FW'(FILTER_LEN - 1)) ? dsync_q[1] : dflt_q;
    cprev_d = cflt_q;
    fall_d  = cprev_q & ~cflt_q;
    bit_d   = dflt_q;
  end
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    pe_d     = 1'b0;
    fe_d     = 1'b0;
    timeout  = state_q != IDLE && to_q == TW'(TIMEOUT - 1);
    to_d     = (fall_q || state_q == IDLE) ? '0 : to_q + TW'(1);
    if (timeout) begin
      state_d = IDLE;
      fe_d    = 1'b1;
      sh_d    = '0;
      to_d    = '0;
    end else if (fall_q) begin
      case (state_q)
        IDLE: begin
          state_d  = bit_q ? IDLE : DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          sh_d     = {bit_q, sh_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d  = (bitcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = bit_q;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          fe_d    = ~bit_q;
          pe_d    = bit_q & ~^{sh_q, par_q};
          dv_d    = bit_q & ^{sh_q, par_q};
          data_d  = (bit_q & ^{sh_q, par_q}) ? sh_q : data_q;
        end
      endcase
    end
  end
  // prefixes accumulate until a plain byte completes the key event
  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    code_d = code_q;
    kext_d = kext_q;
    krel_d = krel_q;
    kv_d   = 1'b0;
    if (pe_q || fe_q) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (dv_q) begin
      if (data_q == 8'hE0) ext_d = 1'b1;
      else if (data_q == 8'hF0) rel_d = 1'b1;
      else begin
        code_d = data_q;
        kext_d = ext_q;
        krel_d = rel_q;
        kv_d   = 1'b1;
        ext_d  = 1'b0;
        rel_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      csync_q  <= 2'b11;
      dsync_q  <= 2'b11;
      ccnt_q   <= '0;
      dcnt_q   <= '0;
      cflt_q   <= 1'b1;
      dflt_q   <= 1'b1;
      cprev_q  <= 1'b1;
      fall_q   <= 1'b0;
      bit_q    <= 1'b1;
      state_q  <= IDLE;
      to_q     <= '0;
      bitcnt_q <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      code_q   <= '0;
      kext_q   <= 1'b0;
      krel_q   <= 1'b0;
      kv_q     <= 1'b0;
    end else begin
      csync_q  <= csync_d;
      dsync_q  <= dsync_d;
      ccnt_q   <= ccnt_d;
      dcnt_q   <= dcnt_d;
      cflt_q   <= cflt_d;
      dflt_q   <= dflt_d;
      cprev_q  <= cprev_d;
      fall_q   <= fall_d;
      bit_q    <= bit_d;
      state_q  <= state_d;
      to_q     <= to_d;
      bitcnt_q <= bitcnt_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      ext_q    <= ext_d;
      rel_q    <= rel_d;
      code_q   <= code_d;
      kext_q   <= kext_d;
      krel_q   <= krel_d;
      kv_q     <= kv_d;
    end
  end
  assign data         = data_q;
  assign data_valid   = dv_q;
  assign parity_err   = pe_q;
  assign frame_err    = fe_q;
  assign busy         = state_q != IDLE;
  assign key_code     = code_q;
  assign key_extended = kext_q;
  assign key_release  = krel_q;
  assign key_valid    = kv_q;
endmodule

// File: tb/tb_ps2_recv.sv
// tb_ps2_recv: directed and random PS/2 frames checked against a frame-level reference model.
module tb_ps2_recv;
  localparam int FL = 8;
  localparam int TO = 3750;
  logic clk_25mhz = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] data, key_code;
  logic data_valid, parity_err, frame_err, busy, key_extended, key_release, key_valid;
  int total = 0, bad = 0, cyc = 0, fall_cyc = 0, dv_cyc = 0, fe_cyc = 0;
  int n_dv = 0, n_pe = 0, n_fe = 0, n_kv = 0, multi = 0;
  int e_dv = 0, e_pe = 0, e_fe = 0, e_kv = 0;
  logic [7:0] e_data = 8'h00, e_kc = 8'h00;
  logic e_ke = 1'b0, e_kr = 1'b0, m_ext = 1'b0, m_rel = 1'b0;

  ps2_recv #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk_25mhz(clk_25mhz), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data(data), .data_valid(data_valid), .parity_err(parity_err), .frame_err(frame_err),
    .busy(busy), .key_code(key_code), .key_extended(key_extended),
    .key_release(key_release), .key_valid(key_valid)
  );

  always #20 clk_25mhz = ~clk_25mhz;
  always @(posedge clk_25mhz) cyc <= cyc + 1;
  always @(negedge clk_25mhz) begin
    if (data_valid) begin n_dv <= n_dv + 1; dv_cyc <= cyc; end
    if (parity_err) n_pe <= n_pe + 1;
    if (frame_err) begin n_fe <= n_fe + 1; fe_cyc <= cyc; end
    if (key_valid) n_kv <= n_kv + 1;
    if (32'(data_valid) + 32'(parity_err) + 32'(frame_err) > 1) multi <= multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dv_count"}, n_dv, e_dv);
    chk({tag, ".pe_count"}, n_pe, e_pe);
    chk({tag, ".fe_count"}, n_fe, e_fe);
    chk({tag, ".kv_count"}, n_kv, e_kv);
    chk({tag, ".data"}, data, e_data);
    chk({tag, ".key_code"}, key_code, e_kc);
    chk({tag, ".key_ext"}, key_extended, e_ke);
    chk({tag, ".key_rel"}, key_release, e_kr);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".one_pulse"}, multi, 0);
  endtask

  // what one frame should produce, from the protocol rules alone
  task automatic model(input logic [7:0] b, input bit par_ok, input bit stop_ok, input bit complete);
    if (!complete || !stop_ok) begin
      e_fe++; m_ext = 1'b0; m_rel = 1'b0;
    end else if (!par_ok) begin
      e_pe++; m_ext = 1'b0; m_rel = 1'b0;
    end else begin
      e_dv++;
      e_data = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else begin
        e_kv++; e_kc = b; e_ke = m_ext; e_kr = m_rel; m_ext = 1'b0; m_rel = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                      input int nbits, input int hp, input bit glitch);
    logic [10:0] f;
    int n;
    f = {stop_ok, (~^b) ^ !par_ok, b, 1'b0};
    n = (nbits == 8) ? 11 : nbits + 1;
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      if (glitch && i == 4) begin
        repeat (3) @(negedge clk_25mhz);
        ps2_data = ~f[i];
        repeat (5) @(negedge clk_25mhz);
        ps2_data = f[i];
        repeat (3) @(negedge clk_25mhz);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_25mhz);
        ps2_clk = 1'b1;
        repeat (hp - 14) @(negedge clk_25mhz);
      end else repeat (hp) @(negedge clk_25mhz);
      ps2_clk = 1'b0;
      fall_cyc = cyc;
      if (glitch && i == 4) begin
        repeat (5) @(negedge clk_25mhz);
        ps2_data = ~f[i];
        repeat (5) @(negedge clk_25mhz);
        ps2_data = f[i];
        repeat (hp - 10) @(negedge clk_25mhz);
      end else repeat (hp) @(negedge clk_25mhz);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                       input bit glitch, input int hp);
    send(b, par_ok, stop_ok, 8, hp, glitch);
    model(b, par_ok, stop_ok, 1'b1);
    repeat (30) @(negedge clk_25mhz);
  endtask

  initial begin
    logic [7:0] b;
    bit pok;
    repeat (5) @(negedge clk_25mhz);
    check_all("reset");
    resetn = 1'b1;
    repeat (20) @(negedge clk_25mhz);

    frame(8'h1C, 1, 1, 0, 1000);
    check_all("make1C");
    chk("latency_dv", dv_cyc - fall_cyc, FL + 4);

    frame(8'hE0, 1, 1, 0, $urandom_range(20, 40));
    frame(8'hF0, 1, 1, 0, $urandom_range(20, 40));
    frame(8'h74, 1, 1, 0, $urandom_range(20, 40));
    check_all("ext_rel74");
    frame(8'h1C, 1, 1, 0, $urandom_range(20, 40));
    check_all("after_prefix");

    frame(8'h1C, 0, 1, 0, $urandom_range(20, 40));
    check_all("parity_bad");
    frame(8'hF0, 1, 1, 0, $urandom_range(20, 40));
    frame(8'($urandom), 0, 1, 0, $urandom_range(20, 40));
    frame(8'h1C, 1, 1, 0, $urandom_range(20, 40));
    check_all("parity_clears_rel");

    frame(8'h1C, 1, 0, 0, $urandom_range(20, 40));
    check_all("stop_bad");

    send(8'h33, 1, 1, 5, $urandom_range(20, 40), 0);
    model(8'h33, 1, 1, 1'b0);
    chk("timeout.busy_before", busy, 1);
    repeat (TO + 60) @(negedge clk_25mhz);
    check_all("timeout");
    chk("timeout.latency", fe_cyc - fall_cyc, FL + 4 + TO);
    frame(8'h29, 1, 1, 0, $urandom_range(20, 40));
    check_all("after_timeout");

    frame(8'hA5, 1, 1, 1, $urandom_range(24, 40));
    check_all("glitch");

    for (int i = 0; i < 8; i++) begin
      b = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 8'hE0 : 8'hF0) : 8'($urandom);
      pok = $urandom_range(0, 4) != 0;
      frame(b, pok, 1, 0, $urandom_range(20, 40));
      check_all("random");
    end

    frame(8'hE0, 1, 1, 0, $urandom_range(20, 40));
    frame(8'h75, 1, 1, 0, $urandom_range(20, 40));
    check_all("pre_reset");
    send(8'h6B, 1, 1, 4, 25, 0);
    chk("rst.busy_before", busy, 1);
    resetn = 1'b0;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.data", data, 0);
    chk("rst.key_code", key_code, 0);
    chk("rst.key_ext", key_extended, 0);
    chk("rst.pulses", {data_valid, parity_err, frame_err, key_valid, key_release}, 0);
    e_data = 8'h00; e_kc = 8'h00; e_ke = 1'b0; e_kr = 1'b0; m_ext = 1'b0; m_rel = 1'b0;
    repeat (5) @(negedge clk_25mhz);
    resetn = 1'b1;
    repeat (10) @(negedge clk_25mhz);
    frame(8'h5A, 1, 1, 0, $urandom_range(20, 40));
    check_all("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
